cam_capture_ctrl: RTL and testbench

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

---
 rtl/cam_capture_ctrl.sv | 111 +++++++++++
 tb/tb_cam_capture_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: captures one camera frame, packing RGB565 byte pairs into RGB332 frame-buffer writes.
// Define CAM_CONTINUOUS_EN to re-arm capture on every frame after the first start.
module cam_capture_ctrl #(
  parameter int H_PIX   = 160,
  parameter int V_LINES = 120,
  parameter int ADDR_W  = 15
) (
  input  logic              pl,
  input  logic              async_reset_n,
  input  logic              start,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        px_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_wr,
  output logic              busy,
  output logic              done,
  output logic              short_frame
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIX * V_LINES - 1);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t            state_q, state_d;
  logic              seen_q, seen_d;
  logic              phase_q, phase_d;
  logic [5:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic              full_q, full_d;
  logic              short_q, short_d;
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    short_d = short_q;
    full_d  = full_q | (wr_q && addr_q == LAST);
    addr_d  = (wr_q && addr_q != LAST) ? addr_q + 1'b1 : addr_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = WAIT_FRAME;
        seen_d  = 1'b0;
      end
      WAIT_FRAME: begin
        seen_d = seen_q | vsync;
        if (seen_q && !vsync) begin
          state_d = CAPTURE;
          addr_d  = '0;
          full_d  = 1'b0;
          phase_d = 1'b0;
        end
      end
      CAPTURE: begin
        // only the bits that survive RGB565->RGB332 are kept from the HI byte
        if (!href) phase_d = 1'b0;
        else if (!full_q && !phase_q) begin
          hi_d    = {px_data[7:5], px_data[2:0]};
          phase_d = 1'b1;
        end else if (!full_q) begin
          data_d  = {hi_q, px_data[4:3]};
          wr_d    = 1'b1;
          phase_d = 1'b0;
        end
        if (vsync) state_d = DONE;
      end
      default: if (!wr_q) begin
        // a write issued alongside the vsync rise lands first; done waits for it
        short_d = !full_q;
`ifdef CAM_CONTINUOUS_EN
        state_d = WAIT_FRAME;
        seen_d  = 1'b1;
        addr_d  = '0;
`else
        state_d = IDLE;
`endif
      end
    endcase
  end
  always_ff @(posedge pl or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q <= IDLE;
      seen_q  <= 1'b0;
      phase_q <= 1'b0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      full_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      full_q  <= full_d;
      short_q <= short_d;
    end
  end
  assign mem_addr    = addr_q;
  assign mem_data    = data_q;
  assign mem_wr      = wr_q;
  assign busy        = state_q == WAIT_FRAME || state_q == CAPTURE;
  assign done        = state_q == DONE && !wr_q;
  assign short_frame = short_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed and randomized frames on a 2x2 buffer, checked against a pixel-list model.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;
  localparam int H = 2, V = 2, AW = 2, NP = H * V;
`ifdef CAM_CONTINUOUS_EN
  localparam int CONT = 1;
`else
  localparam int CONT = 0;
`endif
  logic pl = 0, async_reset_n = 1, start = 0, vsync = 1, href = 0;
  logic [7:0] px_data = 0;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_data;
  logic mem_wr, busy, done, short_frame;
  cam_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .pl(pl), .async_reset_n(async_reset_n), .start(start), .vsync(vsync), .href(href),
    .px_data(px_data), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .busy(busy), .done(done), .short_frame(short_frame));
  always #5 pl = ~pl;
  int passed = 0, total = 0, fails = 0;
  int got[$];
  int exp_q[$];
  int ndone = 0, wr_at_done = 0;
  logic [7:0] fb[4][8];
  int flen[4];
  int fnl = 0, pre_addr = 0, g0 = 0, d0 = 0;
  bit evs = 0;
  always @(negedge pl) begin
    if (mem_wr) got.push_back(int'(mem_addr) * 256 + int'(mem_data));
    if (done) begin
      ndone++;
      wr_at_done = got.size();
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge pl);
    #1;
  endtask
  task automatic do_reset();
    href = 0;
    start = 0;
    async_reset_n = 0;
    tick();
    async_reset_n = 1;
    tick();
  endtask
  task automatic arm();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic set_line(input int li, input int n, input logic [63:0] v);
    flen[li] = n;
    for (int k = 0; k < n; k++) fb[li][k] = v[63-8*k -: 8];
  endtask
  function automatic int rgb332(input logic [7:0] h, input logic [7:0] l);
    int hh, ll;
    hh = int'(h);
    ll = int'(l);
    return (hh / 32) * 32 + (hh % 8) * 4 + (ll / 8) % 4;
  endfunction
  // Each line yields floor(len/2) pixels; the frame holds at most NP of them at consecutive addresses.
  task automatic model();
    exp_q.delete();
    for (int i = 0; i < fnl; i++)
      for (int k = 0; k + 1 < flen[i]; k += 2)
        if (exp_q.size() < NP) exp_q.push_back(exp_q.size() * 256 + rgb332(fb[i][k], fb[i][k+1]));
  endtask
  task automatic drive_frame();
    vsync = 1;
    repeat (3) tick();
    vsync = 0;
    repeat (2) tick();
    for (int i = 0; i < fnl; i++) begin
      for (int j = 0; j < flen[i]; j++) begin
        href = 1;
        px_data = fb[i][j];
        if (evs && i == fnl - 1 && j == flen[i] - 1) vsync = 1;
        tick();
      end
      href = 0;
      px_data = 0;
      repeat (2) tick();
    end
    pre_addr = int'(mem_addr);
    vsync = 1;
    repeat (5) tick();
  endtask
  task automatic check_frame(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".nwr"}, got.size() - g0, n);
    for (int k = 0; k < n; k++)
      if (g0 + k < got.size()) check({tag, ".wr"}, got[g0+k], exp_q[k]);
    check({tag, ".done"}, ndone - d0, 1);
    check({tag, ".wr_before_done"}, wr_at_done - g0, n);
    check({tag, ".short"}, short_frame, n < NP);
    check({tag, ".busy"}, busy, CONT);
    if (!evs) check({tag, ".end_addr"}, pre_addr, n < NP ? n : NP - 1);
  endtask
  task automatic run(input string tag);
    do_reset();
    g0 = got.size();
    d0 = ndone;
    arm();
    model();
    drive_frame();
    check_frame(tag);
  endtask
  initial begin
    #2 async_reset_n = 0;
    #1;
    check("rst.addr", mem_addr, 0);
    check("rst.data", mem_data, 0);
    check("rst.wr", mem_wr, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.short", short_frame, 0);
    tick();
    async_reset_n = 1;
    tick();
    // basic 2x2 frame, data E0,1C,03,FF
    fnl = 2;
    evs = 0;
    set_line(0, 4, 64'hF800_07E0_0000_0000);
    set_line(1, 4, 64'h001F_FFFF_0000_0000);
    do_reset();
    g0 = got.size();
    d0 = ndone;
    arm();
    tick();
    check("basic.busy_armed", busy, 1);
    model();
    drive_frame();
    check_frame("basic");
    if (got.size() >= g0 + 4) begin
      check("basic.px0", got[g0], 'h0E0);
      check("basic.px1", got[g0+1], 'h11C);
      check("basic.px2", got[g0+2], 'h203);
      check("basic.px3", got[g0+3], 'h3FF);
    end
    // armed mid-frame: that frame is skipped
    do_reset();
    g0 = got.size();
    d0 = ndone;
    vsync = 0;
    repeat (2) tick();
    arm();
    for (int j = 0; j < 4; j++) begin
      href = 1;
      px_data = 8'h5A + 8'(j);
      tick();
    end
    href = 0;
    repeat (3) tick();
    check("midframe.nowr", got.size() - g0, 0);
    set_line(0, 4, 64'h1234_5678_0000_0000);
    set_line(1, 4, 64'h9ABC_DEF0_0000_0000);
    model();
    drive_frame();
    check_frame("midframe");
    // odd byte line discards the dangling HI byte
    set_line(0, 5, 64'h1122_3344_5500_0000);
    set_line(1, 4, 64'h6677_8899_0000_0000);
    run("oddline");
    // short frame: 3 of 4 pixels
    set_line(0, 4, 64'hA1B2_C3D4_0000_0000);
    set_line(1, 2, 64'hE5F6_0000_0000_0000);
    run("short");
    // fifth pixel ignored, no address wrap
    set_line(1, 6, 64'hE5F6_0718_293A_0000);
    run("overfull");
    // write pending on the vsync rise cycle
    evs = 1;
    set_line(1, 4, 64'hE5F6_0718_0000_0000);
    run("vsync_lo");
    set_line(1, 2, 64'hE5F6_0000_0000_0000);
    run("vsync_lo_short");
    evs = 0;
    // asynchronous reset mid-frame
    do_reset();
    g0 = got.size();
    d0 = ndone;
    arm();
    vsync = 1;
    repeat (2) tick();
    vsync = 0;
    repeat (2) tick();
    for (int j = 0; j < 4; j++) begin
      href = 1;
      px_data = 8'hC3 + 8'(j);
      tick();
    end
    href = 0;
    repeat (2) tick();
    check("midrst.pre_nwr", got.size() - g0, 2);
    check("midrst.pre_addr", mem_addr, 2);
    async_reset_n = 0;
    #1;
    check("midrst.addr", mem_addr, 0);
    check("midrst.data", mem_data, 0);
    check("midrst.wr", mem_wr, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.short", short_frame, 0);
    tick();
    async_reset_n = 1;
    for (int j = 0; j < 4; j++) begin
      href = 1;
      px_data = 8'h3C + 8'(j);
      tick();
    end
    href = 0;
    set_line(0, 4, 64'h1234_5678_0000_0000);
    set_line(1, 4, 64'h9ABC_DEF0_0000_0000);
    drive_frame();
    check("midrst.post_nwr", got.size() - g0, 2);
    check("midrst.post_done", ndone - d0, 0);
    check("midrst.post_busy", busy, 0);
    // one start, three frames
    do_reset();
    g0 = got.size();
    d0 = ndone;
    arm();
    model();
    repeat (3) drive_frame();
    check("multi.nwr", got.size() - g0, (CONT ? 3 : 1) * NP);
    check("multi.done", ndone - d0, CONT ? 3 : 1);
    for (int k = 0; k < (CONT ? 3 : 1) * NP; k++)
      if (g0 + k < got.size()) check("multi.wr", got[g0+k], exp_q[k % NP]);
    // randomized frames
    for (int r = 0; r < 10; r++) begin
      fnl = 1 + int'($urandom_range(2));
      for (int i = 0; i < fnl; i++) begin
        flen[i] = int'($urandom_range(6));
        for (int k = 0; k < flen[i]; k++) fb[i][k] = 8'($urandom);
      end
      evs = flen[fnl-1] > 0 && $urandom_range(1) == 1;
      run("rand");
    end
    evs = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
